// File: rtl/rf_write_arbiter_if.sv
// Writeback bus between the two result producers, the issue-side claim port and
// the register-file write port of rf_write_arbiter.
interface rf_write_arbiter_if;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        claim_valid;
    logic [4:0]  claim_addr;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic [31:0] pending;

    // Driven by the requesters and the issue stage.
    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output claim_valid, claim_addr,
        input  req0_ready, req1_ready,
        input  A3, WD3, WE3, pending
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  claim_valid, claim_addr,
        output req0_ready, req1_ready,
        output A3, WD3, WE3, pending
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter with a registered write port and a
// per-register pending scoreboard fed by issue-time claims.
module rf_write_arbiter #(
    parameter int unsigned PRIO_MODE = 0
) (
    input logic              CLK,
    input logic              RESET,
    rf_write_arbiter_if.slave bus
);
    localparam bit FixedPrio = (PRIO_MODE == 1);

    // last_q = 1 means req1 was granted most recently.
    logic        last_q, last_d;
    logic        grant0, grant1, accept;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  a3_q;
    logic [31:0] wd3_q;
    logic        we3_q;
    logic [31:0] pending_q, pending_d;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!RESET) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (FixedPrio || last_q) grant0 = 1'b1;
                else                     grant1 = 1'b1;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign accept         = grant0 | grant1;
    assign wr_addr        = grant1 ? bus.req1_addr : bus.req0_addr;
    assign wr_data        = grant1 ? bus.req1_data : bus.req0_data;
    assign last_d         = accept ? grant1 : last_q;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Clear before set so a same-cycle claim to the written register survives.
    always_comb begin
        pending_d = pending_q;
        if (accept) pending_d[wr_addr] = 1'b0;
        if (bus.claim_valid && (bus.claim_addr != 5'd0)) pending_d[bus.claim_addr] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_q    <= 1'b1;
            a3_q      <= 5'd0;
            wd3_q     <= 32'd0;
            we3_q     <= 1'b0;
            pending_q <= 32'd0;
        end else begin
            last_q    <= last_d;
            we3_q     <= accept && (wr_addr != 5'd0);
            pending_q <= pending_d;
            if (accept) begin
                a3_q  <= wr_addr;
                wd3_q <= wr_data;
            end
        end
    end

    assign bus.A3      = a3_q;
    assign bus.WD3     = wd3_q;
    assign bus.WE3     = we3_q;
    assign bus.pending = pending_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a round-robin instance (rr) and a
// fixed-priority instance (fp) share clock and reset.
module tb_rf_write_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    rf_write_arbiter_if rr ();
    rf_write_arbiter_if fp ();

    rf_write_arbiter #(.PRIO_MODE(0)) dut_rr (.CLK(clk), .RESET(rst), .bus(rr));
    rf_write_arbiter #(.PRIO_MODE(1)) dut_fp (.CLK(clk), .RESET(rst), .bus(fp));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rr.req0_valid = 0; rr.req0_addr = 0; rr.req0_data = 0;
        rr.req1_valid = 0; rr.req1_addr = 0; rr.req1_data = 0;
        rr.claim_valid = 0; rr.claim_addr = 0;
        fp.req0_valid = 0; fp.req0_addr = 0; fp.req0_data = 0;
        fp.req1_valid = 0; fp.req1_addr = 0; fp.req1_data = 0;
        fp.claim_valid = 0; fp.claim_addr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        rst = 1;

        // Readies held low under reset even with both requesters valid.
        rr.req0_valid = 1; rr.req1_valid = 1;
        fp.req0_valid = 1; fp.req1_valid = 1;
        #1;
        chk("rst_rr_ready0", 32'(rr.req0_ready), 32'd0);
        chk("rst_rr_ready1", 32'(rr.req1_ready), 32'd0);
        chk("rst_fp_ready0", 32'(fp.req0_ready), 32'd0);
        tick();
        tick();
        chk("rst_we3", 32'(rr.WE3), 32'd0);
        chk("rst_a3", 32'(rr.A3), 32'd0);
        chk("rst_wd3", rr.WD3, 32'd0);
        chk("rst_pending", rr.pending, 32'd0);
        idle_inputs();
        rst = 0;

        // Single write.
        rr.req0_valid = 1; rr.req0_addr = 5; rr.req0_data = 32'hDEADBEEF;
        #1;
        chk("single_ready0", 32'(rr.req0_ready), 32'd1);
        chk("single_ready1", 32'(rr.req1_ready), 32'd0);
        tick();
        rr.req0_valid = 0;
        chk("single_we3", 32'(rr.WE3), 32'd1);
        chk("single_a3", 32'(rr.A3), 32'd5);
        chk("single_wd3", rr.WD3, 32'hDEADBEEF);
        tick();
        chk("single_we3_drop", 32'(rr.WE3), 32'd0);
        chk("single_a3_hold", 32'(rr.A3), 32'd5);
        chk("single_wd3_hold", rr.WD3, 32'hDEADBEEF);

        // Round-robin tie for 4 cycles after reset, req0 wins first.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rr.req0_valid = 1; rr.req0_addr = 5'(i + 1);  rr.req0_data = 32'h1000_0000 + i;
            rr.req1_valid = 1; rr.req1_addr = 5'(i + 10); rr.req1_data = 32'h2000_0000 + i;
            #1;
            chk($sformatf("rr_ready0_%0d", i), 32'(rr.req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr_ready1_%0d", i), 32'(rr.req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            chk($sformatf("rr_we3_%0d", i), 32'(rr.WE3), 32'd1);
            chk($sformatf("rr_a3_%0d", i), 32'(rr.A3), (i % 2 == 0) ? i + 1 : i + 10);
            chk($sformatf("rr_wd3_%0d", i), rr.WD3,
                (i % 2 == 0) ? 32'h1000_0000 + i : 32'h2000_0000 + i);
        end
        rr.req0_valid = 0; rr.req1_valid = 0;
        tick();
        chk("rr_we3_idle", 32'(rr.WE3), 32'd0);

        // Fixed priority: req0 wins every tie, req1 granted once req0 drops.
        for (int i = 0; i < 3; i++) begin
            fp.req0_valid = 1; fp.req0_addr = 5'(i + 20); fp.req0_data = 32'hA000_0000 + i;
            fp.req1_valid = 1; fp.req1_addr = 5'd30;      fp.req1_data = 32'hB0B0_B0B0;
            #1;
            chk($sformatf("fp_ready0_%0d", i), 32'(fp.req0_ready), 32'd1);
            chk($sformatf("fp_ready1_%0d", i), 32'(fp.req1_ready), 32'd0);
            tick();
            chk($sformatf("fp_a3_%0d", i), 32'(fp.A3), i + 20);
        end
        fp.req0_valid = 0;
        #1;
        chk("fp_ready1_after", 32'(fp.req1_ready), 32'd1);
        chk("fp_ready0_after", 32'(fp.req0_ready), 32'd0);
        tick();
        fp.req1_valid = 0;
        chk("fp_we3_req1", 32'(fp.WE3), 32'd1);
        chk("fp_a3_req1", 32'(fp.A3), 32'd30);
        chk("fp_wd3_req1", fp.WD3, 32'hB0B0_B0B0);

        // Scoreboard.
        rr.claim_valid = 1; rr.claim_addr = 7;
        tick();
        rr.claim_valid = 0;
        chk("sb_claim7", rr.pending, 32'h0000_0080);
        rr.req1_valid = 1; rr.req1_addr = 7; rr.req1_data = 32'h77;
        #1;
        chk("sb_ready1", 32'(rr.req1_ready), 32'd1);
        tick();
        rr.req1_valid = 0;
        chk("sb_clear7", rr.pending, 32'd0);
        chk("sb_a3", 32'(rr.A3), 32'd7);
        rr.claim_valid = 1; rr.claim_addr = 7;
        rr.req0_valid = 1; rr.req0_addr = 7; rr.req0_data = 32'h78;
        tick();
        chk("sb_same_cycle", rr.pending, 32'h0000_0080);
        rr.claim_addr = 9;
        rr.req0_addr = 7;
        tick();
        chk("sb_diff_addr", rr.pending, 32'h0000_0200);
        rr.claim_valid = 0;
        rr.req0_addr = 12;
        tick();
        rr.req0_valid = 0;
        chk("sb_not_pending", rr.pending, 32'h0000_0200);

        // Address 0: accepted, never written, never claimed.
        rr.req0_valid = 1; rr.req0_addr = 0; rr.req0_data = 32'h55;
        #1;
        chk("a0_ready0", 32'(rr.req0_ready), 32'd1);
        tick();
        rr.req0_valid = 0;
        chk("a0_we3", 32'(rr.WE3), 32'd0);
        chk("a0_a3", 32'(rr.A3), 32'd0);
        chk("a0_wd3", rr.WD3, 32'h55);
        rr.claim_valid = 1; rr.claim_addr = 0;
        tick();
        rr.claim_valid = 0;
        chk("a0_claim", rr.pending, 32'h0000_0200);

        // Reset right after an accept: the write still commits in the reset cycle.
        rr.req0_valid = 1; rr.req0_addr = 3; rr.req0_data = 32'h33;
        #1;
        chk("mid_ready0", 32'(rr.req0_ready), 32'd1);
        tick();
        rst = 1;
        rr.req0_addr = 4; rr.req0_data = 32'h44;
        rr.req1_valid = 1; rr.req1_addr = 6;
        rr.claim_valid = 1; rr.claim_addr = 20;
        chk("mid_we3", 32'(rr.WE3), 32'd1);
        chk("mid_a3", 32'(rr.A3), 32'd3);
        chk("mid_wd3", rr.WD3, 32'h33);
        #1;
        chk("mid_rst_ready0", 32'(rr.req0_ready), 32'd0);
        chk("mid_rst_ready1", 32'(rr.req1_ready), 32'd0);
        tick();
        chk("mid_post_we3", 32'(rr.WE3), 32'd0);
        chk("mid_post_a3", 32'(rr.A3), 32'd0);
        chk("mid_post_wd3", rr.WD3, 32'd0);
        chk("mid_post_pending", rr.pending, 32'd0);
        idle_inputs();
        rst = 0;
        tick();
        chk("mid_lost_we3", 32'(rr.WE3), 32'd0);
        chk("mid_lost_pending", rr.pending, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter PRIO_MODE, default 0; 0 = round-robin between requesters, 1 = fixed priority with req0 winning.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have port CLK, input, 1 bit: system clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req0_valid, input, 1 bit: requester 0 (ALU/load writeback) has a write pending.
REQ-006 SHALL have port req0_addr, input, 5 bits: destination register for requester 0.
REQ-007 SHALL have port req0_data, input, 32 bits: write data for requester 0.
REQ-008 SHALL have port req0_ready, output, 1 bit: requester 0 write accepted this cycle.
REQ-009 SHALL have ports req1_valid, req1_addr, req1_data and req1_ready, with the same directions, widths and meaning as req0, for requester 1 (multi-cycle mul/div unit).
REQ-010 SHALL have port claim_valid, input, 1 bit: an issuing instruction reserves a destination register.
REQ-011 SHALL have port claim_addr, input, 5 bits: register being reserved.
REQ-012 SHALL have port A3, output, 5 bits: register file write address.
REQ-013 SHALL have port WD3, output, 32 bits: register file write data.
REQ-014 SHALL have port WE3, output, 1 bit: register file write enable.
REQ-015 SHALL have port pending, output, 32 bits: bit i = 1 means register i has an outstanding reserved write.

Function
REQ-016 SHALL accept a request only in a cycle where reqN_valid and reqN_ready are both 1; reqN_ready SHALL be combinational from valid inputs, the priority state and RESET.
REQ-017 SHALL assert at most one reqN_ready per cycle, and SHALL never assert reqN_ready while reqN_valid = 0.
REQ-018 SHALL, with only one requester valid, grant that requester in the same cycle.
REQ-019 SHALL, with both valid and PRIO_MODE = 0, grant the requester not granted most recently; a last-grant flag SHALL update on every accept.
REQ-020 SHALL, with both valid and PRIO_MODE = 1, always grant req0; req1 waits with no starvation guard.
REQ-021 SHALL register the accepted write into A3/WD3/WE3 on the edge ending the accept cycle, giving 1-cycle latency from accept to WE3 = 1.
REQ-022 SHALL hold WE3 = 1 for exactly one cycle per accept, and SHALL set WE3 = 0 in any cycle with no accept.
REQ-023 SHALL, when no write is accepted, hold A3/WD3 at their last values.
REQ-024 SHALL accept a write with address 0 normally (reqN_ready = 1), but SHALL keep WE3 = 0 for it; A3/WD3 still update.
REQ-025 SHALL, on claim_valid with claim_addr != 0, set pending[claim_addr] on the next edge; claims to address 0 SHALL be ignored, so pending[0] is always 0.
REQ-026 SHALL clear pending[reqN_addr] on the edge ending the accept cycle.
REQ-027 SHALL, when a claim and an accepted write target the same address in the same cycle, leave the bit set (set wins, the newer claim).
REQ-028 SHALL make a claim and an accepted write to different addresses in the same cycle both take effect.
REQ-029 SHALL leave pending unchanged by a write to a register that is not pending; this is not an error.

Reset
REQ-030 SHALL, while RESET = 1, force req0_ready = req1_ready = 0 and ignore claims.
REQ-031 SHALL, on the edge with RESET = 1, set WE3 = 0, A3 = 0, WD3 = 0, pending = 0 and the last-grant flag to "req1", so req0 wins the first tie.
REQ-032 SHALL, if RESET asserts one cycle after an accept, still commit that write (WE3 = 1 in the RESET cycle), then clear the output registers on the RESET edge; writes that were offered but not accepted SHALL be lost.

Verification
REQ-033 SHALL be verified for a single write: req0 valid with addr 5 and data 0xDEADBEEF -> req0_ready = 1 that cycle; next cycle A3 = 5, WD3 = 0xDEADBEEF, WE3 = 1 for one cycle only.
REQ-034 SHALL be verified for round-robin: both requesters valid for 4 cycles (PRIO_MODE = 0) after reset -> grants alternate req0, req1, req0, req1; WE3 = 1 on 4 consecutive cycles with matching addr/data.
REQ-035 SHALL be verified for fixed priority: PRIO_MODE = 1 with both valid for 3 cycles -> req0 granted all 3 cycles, req1_ready stays 0; req1 is granted the cycle after req0 drops.
REQ-036 SHALL be verified for the scoreboard: claim addr 7 -> pending = 0x00000080; req1 writes addr 7 -> pending = 0 after the accept edge; a same-cycle claim 7 and write 7 -> pending stays 0x00000080.
REQ-037 SHALL be verified for address 0: write addr 0 -> accepted, WE3 stays 0; claim addr 0 -> pending stays 0.
REQ-038 SHALL be verified for reset mid-stream: accept addr 3, then assert RESET -> WE3 = 1 for addr 3 in the RESET cycle, then WE3/A3/WD3/pending = 0, and both readies stay 0 while RESET = 1.
